toom_8: RTL and testbench
=========================

Name: toom_8

Overview:
- Front end and reference product path for a Toom-Cook-8 multiplier operating on 1024-bit operands.
- Registers two 1024-bit inputs and splits each into eight 128-bit limbs, exposed as 129-bit zero-extended chunks. The extra bit is headroom for downstream evaluation arithmetic.
- Computes the full 2048-bit product by recombining limb partial products, giving later Toom evaluation/interpolation stages a golden result.

Parameters:
- LIMB_W, 128, width of one limb.
- N_LIMBS, 8, number of limbs per operand; fixed at 8, not a generic Toom-k.
- CHUNK_W, 129, width of a chunk output (LIMB_W+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- X  in  1024  operand A.
- Y  in  1024  operand B.
- product  out  2048  X*Y, unsigned.
- A_chunk0..A_chunk7  out  129 each  limbs of X; chunk0 = X[127:0], chunkk = X[128k+127:128k], bit 128 = 0.
- B_chunk0..B_chunk7  out  129 each  limbs of Y, same mapping.

Behaviour:
- One clock domain. Reset is synchronous and active-high. While rst=1 at a rising edge, every register (chunks, partial-product stage, product) loads 0.
- Stage 1 (edge N): A_chunk k <= {1'b0, X[128k+:128]} and B_chunk k <= {1'b0, Y[128k+:128]}. Chunk outputs reflect inputs sampled one edge earlier, so latency is 1 cycle.
- Stage 2 (edge N+1): from the registered chunks, form coefficients c_m = sum over i+j=m of A_i*B_j, for m = 0..14. Each c_m is 256+3 = 259 bits.
  - product <= sum of c_m << (128*m), truncated to 2048 bits. The true result always fits, so truncation never discards set bits.
  - Product latency is 2 cycles from input sampling.
- Fully pipelined: a new X/Y pair is accepted every cycle; there is no handshake and no stall.
- Unsigned arithmetic only; bit 128 of every chunk is always 0.
- Boundary cases:
  - X=0 or Y=0 gives product 0.
  - All-ones operands give the maximum product with no overflow.
  - A reset asserted mid-pipeline flushes both stages; outputs are 0 on the cycle after the reset edge, and valid data resumes 1 cycle (chunks) and 2 cycles (product) after rst deasserts.
- Outputs are purely registered; there is no combinational input-to-output path.

Decomposition:
- Shared package toom_pkg: LIMB_W, N_LIMBS, CHUNK_W, OPERAND_W=1024, PRODUCT_W=2048, and a chunk_t typedef (logic [CHUNK_W-1:0]).
- One sub-module is natural: toom_splitter, which performs the registered limb extraction and zero-extension for one operand. It is instantiated twice, once for X and once for Y.
- Coefficient accumulation and recombination stay in the top level.

Test Plan:
- Reset: hold rst=1 for 3 cycles with X=Y=all ones -> every chunk and product read 0. After release, chunks are valid after 1 cycle and product after 2 cycles.
- Small limbs: X=Y={8,7,6,5,4,3,2,253} (chunk7..chunk0, 128 bits each) -> after 1 cycle A_chunk0=B_chunk0=253 and A_chunk7=8.
  - After 2 cycles, product 128-bit slices from the bottom are 64009, 1012, 1522, ..., 112 (slice 13), 64 (slice 14), 0 (slice 15).
  - There are no inter-slice carries.
- Maximum: X=Y=2^1024-1 -> every chunk = 0x0_FFFF…F (bit128=0, 128 ones); product = 2^2048 - 2^1025 + 1.
- Asymmetric: X=1, Y=2^1023 -> A_chunk0=1, B_chunk7=2^127, product=2^1023. X=2^128, Y=2^128 -> product=2^256, with only coefficient c_2 nonzero.
- Throughput: apply a different random pair on each of 10 consecutive cycles -> every product matches a reference X*Y exactly 2 cycles later, and chunks match exactly 1 cycle later.
- Mid-stream reset: pulse rst for 1 cycle while the pipeline is full -> the next cycle shows all zeros. Pairs applied after release produce correct results with the same latencies, and no stale data appears.

Source files
------------

// File: rtl/toom_pkg.sv
// Shared widths and types for the Toom-Cook-8 front end and its reference product path.
package toom_pkg;

    localparam int LIMB_W    = 128;
    localparam int N_LIMBS   = 8;
    localparam int CHUNK_W   = LIMB_W + 1;
    localparam int OPERAND_W = LIMB_W * N_LIMBS;
    localparam int PRODUCT_W = 2 * OPERAND_W;

    // A coefficient sums up to eight 256-bit limb products, so it needs three extra bits.
    localparam int COEFF_W   = 2 * LIMB_W + 3;
    localparam int N_COEFF   = 2 * N_LIMBS - 1;

    typedef logic [CHUNK_W-1:0] chunk_t;

endpackage

// File: rtl/toom_8_if.sv
// Bundles the operand inputs, the limb chunks and the reference product into one bus.
interface toom_8_if;
    import toom_pkg::*;

    logic [OPERAND_W-1:0] X;
    logic [OPERAND_W-1:0] Y;
    logic [PRODUCT_W-1:0] product;

    chunk_t A_chunk0, A_chunk1, A_chunk2, A_chunk3;
    chunk_t A_chunk4, A_chunk5, A_chunk6, A_chunk7;
    chunk_t B_chunk0, B_chunk1, B_chunk2, B_chunk3;
    chunk_t B_chunk4, B_chunk5, B_chunk6, B_chunk7;

    modport master (
        output X, Y,
        input  product,
        input  A_chunk0, A_chunk1, A_chunk2, A_chunk3,
        input  A_chunk4, A_chunk5, A_chunk6, A_chunk7,
        input  B_chunk0, B_chunk1, B_chunk2, B_chunk3,
        input  B_chunk4, B_chunk5, B_chunk6, B_chunk7
    );

    modport slave (
        input  X, Y,
        output product,
        output A_chunk0, A_chunk1, A_chunk2, A_chunk3,
        output A_chunk4, A_chunk5, A_chunk6, A_chunk7,
        output B_chunk0, B_chunk1, B_chunk2, B_chunk3,
        output B_chunk4, B_chunk5, B_chunk6, B_chunk7
    );

endinterface

// File: rtl/toom_splitter.sv
// Registers one operand and splits it into eight zero-extended limb chunks.
module toom_splitter
    import toom_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] operand,
    output chunk_t               chunk [N_LIMBS]
);

    // The spare top bit of every chunk is headroom for later evaluation sums, so it loads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_LIMBS; k++) begin
                chunk[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_LIMBS; k++) begin
                chunk[k] <= {1'b0, operand[LIMB_W*k +: LIMB_W]};
            end
        end
    end

endmodule

// File: rtl/toom_8.sv
// Toom-Cook-8 front end: registered limb split plus a golden schoolbook product one stage later.
module toom_8
    import toom_pkg::*;
(
    input  logic clk,
    input  logic rst,
    toom_8_if.slave bus
);

    chunk_t a_chunk [N_LIMBS];
    chunk_t b_chunk [N_LIMBS];

    logic [COEFF_W-1:0]   coeff [N_COEFF];
    logic [PRODUCT_W-1:0] product_sum;
    logic [PRODUCT_W-1:0] product_q;

    toom_splitter u_split_x (
        .clk     (clk),
        .rst     (rst),
        .operand (bus.X),
        .chunk   (a_chunk)
    );

    toom_splitter u_split_y (
        .clk     (clk),
        .rst     (rst),
        .operand (bus.Y),
        .chunk   (b_chunk)
    );

    // Coefficient m collects every limb product whose indices sum to m; the recombination then
    // places each coefficient at its 128-bit weight. Overlapping coefficients carry naturally.
    always_comb begin
        for (int m = 0; m < N_COEFF; m++) begin
            coeff[m] = '0;
        end
        for (int i = 0; i < N_LIMBS; i++) begin
            for (int j = 0; j < N_LIMBS; j++) begin
                coeff[i+j] = coeff[i+j] + COEFF_W'(a_chunk[i]) * COEFF_W'(b_chunk[j]);
            end
        end
        product_sum = '0;
        for (int m = 0; m < N_COEFF; m++) begin
            product_sum = product_sum + (PRODUCT_W'(coeff[m]) << (LIMB_W * m));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q <= '0;
        end else begin
            product_q <= product_sum;
        end
    end

    assign bus.product  = product_q;

    assign bus.A_chunk0 = a_chunk[0];
    assign bus.A_chunk1 = a_chunk[1];
    assign bus.A_chunk2 = a_chunk[2];
    assign bus.A_chunk3 = a_chunk[3];
    assign bus.A_chunk4 = a_chunk[4];
    assign bus.A_chunk5 = a_chunk[5];
    assign bus.A_chunk6 = a_chunk[6];
    assign bus.A_chunk7 = a_chunk[7];

    assign bus.B_chunk0 = b_chunk[0];
    assign bus.B_chunk1 = b_chunk[1];
    assign bus.B_chunk2 = b_chunk[2];
    assign bus.B_chunk3 = b_chunk[3];
    assign bus.B_chunk4 = b_chunk[4];
    assign bus.B_chunk5 = b_chunk[5];
    assign bus.B_chunk6 = b_chunk[6];
    assign bus.B_chunk7 = b_chunk[7];

endmodule

// File: tb/tb_toom_8.sv
// Bench for toom_8: directed corner cases and random pairs checked against a plain X*Y model.
module tb_toom_8;
    import toom_pkg::*;

    logic clk;
    logic rst;

    toom_8_if bus ();

    toom_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    chunk_t a_obs [N_LIMBS];
    chunk_t b_obs [N_LIMBS];

    assign a_obs[0] = bus.A_chunk0;
    assign a_obs[1] = bus.A_chunk1;
    assign a_obs[2] = bus.A_chunk2;
    assign a_obs[3] = bus.A_chunk3;
    assign a_obs[4] = bus.A_chunk4;
    assign a_obs[5] = bus.A_chunk5;
    assign a_obs[6] = bus.A_chunk6;
    assign a_obs[7] = bus.A_chunk7;
    assign b_obs[0] = bus.B_chunk0;
    assign b_obs[1] = bus.B_chunk1;
    assign b_obs[2] = bus.B_chunk2;
    assign b_obs[3] = bus.B_chunk3;
    assign b_obs[4] = bus.B_chunk4;
    assign b_obs[5] = bus.B_chunk5;
    assign b_obs[6] = bus.B_chunk6;
    assign b_obs[7] = bus.B_chunk7;

    // Model state: the operands the DUT should be holding after each edge, and the product
    // it should present, both derived from plain multiplication of whole operands.
    logic [OPERAND_W-1:0] m_x1 = '0;
    logic [OPERAND_W-1:0] m_y1 = '0;
    logic [PRODUCT_W-1:0] m_prod = '0;

    function automatic logic [OPERAND_W-1:0] rand_operand();
        logic [OPERAND_W-1:0] r;
        for (int w = 0; w < OPERAND_W / 32; w++) begin
            r[32*w +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic chunk_t model_chunk(input logic [OPERAND_W-1:0] v, input int k);
        logic [OPERAND_W-1:0] sh;
        sh = v >> (LIMB_W * k);
        return {1'b0, sh[LIMB_W-1:0]};
    endfunction

    task automatic check_chunk(input string tag, input chunk_t obs, input chunk_t exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wide mismatches are reported by their lowest differing 128-bit slice to keep lines short.
    task automatic check_prod(input string tag, input logic [PRODUCT_W-1:0] obs,
                              input logic [PRODUCT_W-1:0] exp);
        int bad;
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            bad = 0;
            for (int s = PRODUCT_W / LIMB_W - 1; s >= 0; s--) begin
                if (obs[LIMB_W*s +: LIMB_W] !== exp[LIMB_W*s +: LIMB_W]) bad = s;
            end
            $error("[TB] FAIL %s slice%0d observed=%h expected=%h", tag, bad,
                   obs[LIMB_W*bad +: LIMB_W], exp[LIMB_W*bad +: LIMB_W]);
        end
    endtask

    task automatic check_slice(input string tag, input int s, input logic [LIMB_W-1:0] exp);
        logic [LIMB_W-1:0] obs;
        obs = bus.product[LIMB_W*s +: LIMB_W];
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s slice%0d observed=%0d expected=%0d", tag, s, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int k = 0; k < N_LIMBS; k++) begin
            check_chunk($sformatf("%s.A%0d", tag, k), a_obs[k], model_chunk(m_x1, k));
            check_chunk($sformatf("%s.B%0d", tag, k), b_obs[k], model_chunk(m_y1, k));
        end
        check_prod({tag, ".prod"}, bus.product, m_prod);
    endtask

    // Drive one pair for one edge, advance the model, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic [OPERAND_W-1:0] x, input logic [OPERAND_W-1:0] y,
                                 input logic r, input string tag);
        bus.X = x;
        bus.Y = y;
        rst   = r;
        @(posedge clk);
        m_prod = r ? '0 : (PRODUCT_W'(m_x1) * PRODUCT_W'(m_y1));
        m_x1   = r ? '0 : x;
        m_y1   = r ? '0 : y;
        #1;
        checkOutput(tag);
    endtask

    logic [OPERAND_W-1:0] ones;
    logic [OPERAND_W-1:0] small_op;
    logic [OPERAND_W-1:0] one_op;
    logic [OPERAND_W-1:0] top_bit;
    logic [OPERAND_W-1:0] limb1_bit;
    logic [PRODUCT_W-1:0] max_prod;
    logic [PRODUCT_W-1:0] exp_wide;

    initial begin
        ones      = '1;
        one_op    = OPERAND_W'(1);
        top_bit   = one_op << (OPERAND_W - 1);
        limb1_bit = one_op << LIMB_W;
        small_op  = '0;
        small_op[LIMB_W*0 +: LIMB_W] = LIMB_W'(253);
        for (int k = 1; k < N_LIMBS; k++) begin
            small_op[LIMB_W*k +: LIMB_W] = LIMB_W'(k + 1);
        end
        max_prod = ('1 - (PRODUCT_W'(1) << (OPERAND_W + 1))) + PRODUCT_W'(2);

        bus.X = ones;
        bus.Y = ones;
        rst   = 1'b1;

        // Reset held with all-ones operands must keep everything at zero.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(ones, ones, 1'b1, "reset");
        end
        check_prod("reset_prod_zero", bus.product, '0);
        check_chunk("reset_A7_zero", bus.A_chunk7, '0);

        // Small limbs: recombination without any inter-slice carries.
        applyStimulus(small_op, small_op, 1'b0, "small_in");
        check_chunk("small_A0", bus.A_chunk0, chunk_t'(253));
        check_chunk("small_B0", bus.B_chunk0, chunk_t'(253));
        check_chunk("small_A7", bus.A_chunk7, chunk_t'(8));
        applyStimulus('0, rand_operand(), 1'b0, "small_out");
        check_slice("small", 0, LIMB_W'(64009));
        check_slice("small", 1, LIMB_W'(1012));
        check_slice("small", 2, LIMB_W'(1522));
        check_slice("small", 13, LIMB_W'(112));
        check_slice("small", 14, LIMB_W'(64));
        check_slice("small", 15, LIMB_W'(0));

        // Zero operands on either side.
        applyStimulus(rand_operand(), '0, 1'b0, "x_zero");
        check_prod("x_zero_prod", bus.product, '0);
        applyStimulus(ones, ones, 1'b0, "y_zero");
        check_prod("y_zero_prod", bus.product, '0);
        check_chunk("max_A3", bus.A_chunk3, {1'b0, {LIMB_W{1'b1}}});
        check_chunk("max_B6", bus.B_chunk6, {1'b0, {LIMB_W{1'b1}}});

        // Maximum operands, then asymmetric and single-coefficient products.
        applyStimulus(one_op, top_bit, 1'b0, "asym_in");
        check_prod("max_prod", bus.product, max_prod);
        check_chunk("asym_A0", bus.A_chunk0, chunk_t'(1));
        check_chunk("asym_B7", bus.B_chunk7, chunk_t'(1) << (LIMB_W - 1));
        applyStimulus(limb1_bit, limb1_bit, 1'b0, "c2_in");
        exp_wide = PRODUCT_W'(1) << (OPERAND_W - 1);
        check_prod("asym_prod", bus.product, exp_wide);
        applyStimulus('0, '0, 1'b0, "c2_out");
        exp_wide = PRODUCT_W'(1) << (2 * LIMB_W);
        check_prod("c2_prod", bus.product, exp_wide);

        // Back-to-back random pairs at full rate.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(rand_operand(), rand_operand(), 1'b0, $sformatf("thru%0d", c));
        end

        // A one-cycle reset with the pipeline full must flush both stages.
        applyStimulus(rand_operand(), rand_operand(), 1'b0, "pre_rst");
        applyStimulus(rand_operand(), rand_operand(), 1'b1, "mid_rst");
        check_prod("mid_rst_prod", bus.product, '0);
        check_chunk("mid_rst_A0", bus.A_chunk0, '0);
        applyStimulus(rand_operand(), rand_operand(), 1'b0, "post_rst0");
        check_prod("post_rst_prod_still_zero", bus.product, '0);
        for (int c = 1; c < 5; c++) begin
            applyStimulus(rand_operand(), rand_operand(), 1'b0, $sformatf("post_rst%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
